// File: rtl/microwave_timer.sv
// microwave_timer: countdown timer core of the microwave.
// Captures cooking time as BCD keypad digits (shifted in from the right), counts
// the time down once per TICK_DIV clock cycles while running, and drives the
// magnetron enable. Range 0:00..9:59.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   key_valid, key_digit    keypad strobe and BCD digit
//   start, stop, clear      1-cycle control strobes
//   door_closed             level, 1 = door shut
//   min, sec_tens, sec_ones registered BCD time digits
//   mag_on                  registered magnetron enable, 1 only while running
//   done                    registered, 1 while the finished state is held
module microwave_timer #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;

  logic       time_zero;
  logic       last_sec;
  logic [3:0] dec_min;
  logic [3:0] dec_tens;
  logic [3:0] dec_ones;

  assign time_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  // The tick that consumes the final second is the one that finishes cooking.
  assign last_sec  = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // BCD decrement with borrow chain ones -> tens (base 6) -> minutes.
  always_comb begin
    dec_min  = min;
    dec_tens = sec_tens;
    dec_ones = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = sec_tens - 4'd1;
      if (sec_tens == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      presc    <= '0;
      min      <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      presc    <= '0;
      min      <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // start takes precedence; a key arriving with it is dropped even if
          // the start itself is refused.
          if (start) begin
            if (door_closed && !time_zero) begin
              state  <= RUN;
              presc  <= '0;
              mag_on <= 1'b1;
            end
          end else if (key_valid && (key_digit <= 4'd9) && (sec_ones <= 4'd5)) begin
            min      <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= key_digit;
          end
        end

        RUN: begin
          if (stop || !door_closed) begin
            // Pausing suppresses any tick due on this edge.
            state  <= PAUSE;
            mag_on <= 1'b0;
          end else if (presc == PMAX) begin
            presc    <= '0;
            min      <= dec_min;
            sec_tens <= dec_tens;
            sec_ones <= dec_ones;
            if (last_sec) begin
              state  <= DONE;
              mag_on <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        PAUSE: begin
          if (stop) begin
            state    <= IDLE;
            presc    <= '0;
            min      <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
          end else if (start && door_closed) begin
            state  <= RUN;
            mag_on <= 1'b1;
          end
        end

        DONE: begin
          if (start || stop || !door_closed) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
